prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that writes 16-bit instructions into the processor's instruction memory. It accepts a framed byte stream on a valid/ready handshake: a count byte, instruction bytes sent high byte first, then an XOR checksum byte. It drives the instruction-memory write port and holds the CPU in reset until a load completes cleanly. It sits between the host/debug link and the instruction memory, as the writer of the memory the CPU fetches from.

## Interface
- `CHECK_EN`, default 1: 1 = checksum byte expected and verified; 0 = no checksum byte, go straight to DONE.
- `BASE_ADDR`, default 8'h00: first instruction-memory address written.
- `HOLD_ON_RESET`, default 1: value of `cpu_hold` out of reset.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse that begins a load.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output 8: write address.
- `imem_wdata` output 16: write data.
- `cpu_hold` output 1: CPU reset request.
- `busy` output 1: a load is in progress.
- `done` output 1: sticky; last load succeeded.
- `err` output 1: sticky; last load failed its checksum.

## Operation
- States: IDLE, HDR, HI, LO, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start` -> HDR. On this transition:
  - `done`, `err` and the checksum accumulator clear.
  - `addr` is loaded with `BASE_ADDR`.
  - `cpu_hold` goes to 1.
- `start` in HDR, HI, LO, WRITE or CSUM is ignored.
- HDR: the accepted byte is the word count N. 0x00 means 256 words. -> HI.
- HI: the accepted byte goes to `wdata[15:8]`. -> LO.
- LO: the accepted byte goes to `wdata[7:0]`. -> WRITE.
- WRITE: `imem_we`=1 for this cycle only, using the current `addr`/`wdata`. Then:
  - `addr` increments modulo 256 (0xFF -> 0x00).
  - The remaining count decrements.
  - Next state: HI if words remain; otherwise CSUM (`CHECK_EN`=1) or DONE (`CHECK_EN`=0).
- Checksum: XOR of the count byte and every data byte. CSUM compares the accepted byte to the accumulator.
  - Equal -> DONE: `done`=1, `cpu_hold`=0.
  - Not equal -> ERR: `err`=1, `cpu_hold` stays 1.
- Words already written are never rolled back on ERR.
- `rx_ready` = 1 exactly in HDR, HI, LO, CSUM. A byte is consumed only on `rx_valid && rx_ready` at the rising edge. States hold indefinitely while `rx_valid`=0.
- `busy` = 1 in HDR through CSUM.
- Counting width: the remaining count is held in 9 bits (1..256).

## Timing
- Reset values:
  - state = IDLE.
  - `rx_ready`, `imem_we`, `busy`, `done`, `err` = 0.
  - `imem_addr` = `BASE_ADDR`; `imem_wdata` = 0.
  - `cpu_hold` = `HOLD_ON_RESET`.
- Reset during a load: return to reset values on the next edge. No further writes occur, and words already written stay in memory.
- `start` to HDR: 1 cycle. `rx_ready` is high in the cycle after the `start` pulse.
- Per word at full rate: 3 cycles (HI, LO, WRITE). `rx_ready` is low during WRITE.
- The LO byte-accept edge is followed by the `imem_we` cycle. The memory captures the data at the end of that cycle.
- Full N-word load at full rate: 1 + 3N cycles from HDR entry to the checksum accept, plus 1 cycle to DONE/ERR.
- `done`/`err`/`cpu_hold` change on the edge that accepts the checksum byte, or the edge leaving the final WRITE when `CHECK_EN`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `rx_valid` to `rx_ready`.

## Structure
- Package `prog_loader_pkg` holds:
  - The state enum.
  - `BYTE_W`=8, `INSTR_W`=16, `IMEM_ADDR_W`=8.
  - `MAX_WORDS`=256.
- Single flat module; no sub-module. The checksum accumulator and byte assembly are inline.

## Test plan
- Nominal load, `BASE_ADDR`=0: `start`, then bytes 02,1A,23,2B,45,55 -> writes 0x1A23@0x00 and 0x2B45@0x01; `done`=1, `err`=0; `cpu_hold` falls on the checksum-accept edge; 8 cycles from HDR entry to DONE.
- Bad checksum: same stream with 0x54 last -> both words still written; `err`=1, `done`=0, `cpu_hold`=1. A second `start` with a correct stream -> `err` clears, `done`=1.
- Backpressure/gaps: same stream with `rx_valid` deasserted randomly, and held high through the WRITE cycles -> identical writes, no byte lost or duplicated, `imem_we` pulses exactly twice.
- Wrap/max count: `BASE_ADDR`=0xFE, count 0x00 (256 words) -> 256 writes at addresses FE, FF, 00, ... FD; the checksum covers all 513 bytes.
- Reset mid-load: reset after the first WRITE -> all outputs at reset values, no further `imem_we`. A new `start` loads correctly from `BASE_ADDR`.
- `start` while busy: pulse `start` during LO -> ignored; load completes normally. `CHECK_EN`=0 variant: 1 word 0xF000 -> DONE directly after WRITE, no checksum byte consumed.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the byte-stream program loader.
package prog_loader_pkg;

   localparam int BYTE_W      = 8;
   localparam int INSTR_W     = 16;
   localparam int IMEM_ADDR_W = 8;
   localparam int MAX_WORDS   = 256;
   localparam int CNT_W       = $clog2(MAX_WORDS) + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      HI,
      LO,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// Loads a framed byte stream (count, high/low instruction bytes, XOR checksum)
// into instruction memory and holds the CPU in reset until a clean load.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter bit                     CHECK_EN      = 1'b1,
   parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR     = 8'h00,
   parameter bit                     HOLD_ON_RESET = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [BYTE_W-1:0]      rx_data,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [INSTR_W-1:0]     imem_wdata,
   output logic                   cpu_hold,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   state_t                 state;
   logic [IMEM_ADDR_W-1:0] addr;
   logic [INSTR_W-1:0]     wdata;
   logic [CNT_W-1:0]       remaining;
   logic [BYTE_W-1:0]      csum;
   logic                   accept;

   // Handshake and status outputs decode the state only, never rx_valid.
   assign rx_ready   = (state == HDR) || (state == HI) || (state == LO) || (state == CSUM);
   assign busy       = (state == HDR) || (state == HI) || (state == LO) ||
                       (state == WRITE) || (state == CSUM);
   assign imem_we    = (state == WRITE);
   assign imem_addr  = addr;
   assign imem_wdata = wdata;
   assign accept     = rx_valid && rx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= BASE_ADDR;
         wdata     <= '0;
         remaining <= '0;
         csum      <= '0;
         cpu_hold  <= HOLD_ON_RESET;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= HDR;
                  addr     <= BASE_ADDR;
                  csum     <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
               end
            end
            HDR: begin
               if (accept) begin
                  // A zero count byte encodes the maximum load size.
                  remaining <= (rx_data == '0) ? CNT_W'(MAX_WORDS) : CNT_W'(rx_data);
                  csum      <= csum ^ rx_data;
                  state     <= HI;
               end
            end
            HI: begin
               if (accept) begin
                  wdata[15:8] <= rx_data;
                  csum        <= csum ^ rx_data;
                  state       <= LO;
               end
            end
            LO: begin
               if (accept) begin
                  wdata[7:0] <= rx_data;
                  csum       <= csum ^ rx_data;
                  state      <= WRITE;
               end
            end
            WRITE: begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
               if (remaining == CNT_W'(1)) begin
                  if (CHECK_EN) begin
                     state <= CSUM;
                  end else begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end
               end else begin
                  state <= HI;
               end
            end
            CSUM: begin
               if (accept) begin
                  if (rx_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     err   <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: three instances cover the
// default configuration, an address-wrapping base, and checksum-disabled mode.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        resetSig [3];
   logic        startSig [3];
   logic [7:0]  rxData   [3];
   logic        rxValid  [3];
   logic        rxReady  [3];
   logic        imemWe   [3];
   logic [7:0]  imemAddr [3];
   logic [15:0] imemWdata[3];
   logic        cpuHold  [3];
   logic        busySig  [3];
   logic        doneSig  [3];
   logic        errSig   [3];

   int errors = 0;
   int checks = 0;

   logic [23:0] obsLog[3][512];
   int          obsCnt[3];
   int          busyCnt[3];
   logic [15:0] loadWords[256];

   always #5 clk = ~clk;

   prog_loader u0 (
      .clk(clk), .reset(resetSig[0]), .start(startSig[0]), .rx_data(rxData[0]),
      .rx_valid(rxValid[0]), .rx_ready(rxReady[0]), .imem_we(imemWe[0]),
      .imem_addr(imemAddr[0]), .imem_wdata(imemWdata[0]), .cpu_hold(cpuHold[0]),
      .busy(busySig[0]), .done(doneSig[0]), .err(errSig[0]));

   prog_loader #(.BASE_ADDR(8'hFE)) u1 (
      .clk(clk), .reset(resetSig[1]), .start(startSig[1]), .rx_data(rxData[1]),
      .rx_valid(rxValid[1]), .rx_ready(rxReady[1]), .imem_we(imemWe[1]),
      .imem_addr(imemAddr[1]), .imem_wdata(imemWdata[1]), .cpu_hold(cpuHold[1]),
      .busy(busySig[1]), .done(doneSig[1]), .err(errSig[1]));

   prog_loader #(.CHECK_EN(1'b0)) u2 (
      .clk(clk), .reset(resetSig[2]), .start(startSig[2]), .rx_data(rxData[2]),
      .rx_valid(rxValid[2]), .rx_ready(rxReady[2]), .imem_we(imemWe[2]),
      .imem_addr(imemAddr[2]), .imem_wdata(imemWdata[2]), .cpu_hold(cpuHold[2]),
      .busy(busySig[2]), .done(doneSig[2]), .err(errSig[2]));

   // Log every memory write and count busy cycles, sampled mid-cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (imemWe[d] && obsCnt[d] < 512) begin
            obsLog[d][obsCnt[d]] = {imemAddr[d], imemWdata[d]};
            obsCnt[d] = obsCnt[d] + 1;
         end
         if (busySig[d]) busyCnt[d] = busyCnt[d] + 1;
      end
   end

   // Bound the whole run so a stuck handshake cannot hang the simulation.
   initial begin
      #500us;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Present one byte and return just after the edge that consumes it.
   task automatic applyStimulus(input int d, input logic [7:0] b, input bit gaps,
                                input bit pulseStart);
      int waitCycles = 0;
      if (gaps) begin
         rxValid[d] = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rxData[d]  = b;
      rxValid[d] = 1'b1;
      if (pulseStart) startSig[d] = 1'b1;
      while (!rxReady[d] && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      if (waitCycles >= 200) checkOutput("rxReadyTimeout", 32'd0, 32'd1);
      @(negedge clk);
      startSig[d] = 1'b0;
   endtask

   task automatic pulseStart(input int d);
      startSig[d] = 1'b1;
      @(negedge clk);
      startSig[d] = 1'b0;
   endtask

   // Run a complete load of loadWords[0..n-1] and check it against the
   // frame-level expectations: written words, checksum verdict, status.
   task automatic runLoad(input int d, input int n, input logic [7:0] base,
                          input bit checkEn, input bit corrupt, input bit gaps,
                          input bit startInLo);
      logic [7:0] acc;
      logic [7:0] countByte;
      logic [7:0] expAddr;
      bit         good;
      countByte  = 8'(n);
      obsCnt[d]  = 0;
      busyCnt[d] = 0;
      pulseStart(d);
      checkOutput("rxReadyAfterStart", 32'(rxReady[d]), 32'd1);
      checkOutput("holdDuringLoad", 32'(cpuHold[d]), 32'd1);
      acc = countByte;
      applyStimulus(d, countByte, gaps, 1'b0);
      for (int i = 0; i < n; i++) begin
         applyStimulus(d, loadWords[i][15:8], gaps, 1'b0);
         applyStimulus(d, loadWords[i][7:0], gaps, startInLo && (i == 0));
         acc = acc ^ loadWords[i][15:8] ^ loadWords[i][7:0];
      end
      if (checkEn) begin
         applyStimulus(d, corrupt ? (acc ^ 8'h01) : acc, gaps, 1'b0);
         good = !corrupt;
      end else begin
         @(negedge clk);
         good = 1'b1;
      end
      rxValid[d] = 1'b0;
      checkOutput("done", 32'(doneSig[d]), 32'(good));
      checkOutput("err", 32'(errSig[d]), 32'(!good));
      checkOutput("cpuHold", 32'(cpuHold[d]), 32'(!good));
      checkOutput("busyEnd", 32'(busySig[d]), 32'd0);
      if (!gaps) checkOutput("busyCycles", busyCnt[d], checkEn ? 32'(2 + 3 * n) : 32'(1 + 3 * n));
      checkOutput("writeCount", obsCnt[d], n);
      for (int i = 0; i < n && i < obsCnt[d]; i++) begin
         expAddr = base + 8'(i);
         checkOutput("writeAddr", 32'(obsLog[d][i][23:16]), 32'(expAddr));
         checkOutput("writeData", 32'(obsLog[d][i][15:0]), 32'(loadWords[i]));
      end
   endtask

   task automatic checkResetValues(input int d, input logic [7:0] base);
      checkOutput("rstRxReady", 32'(rxReady[d]), 32'd0);
      checkOutput("rstImemWe", 32'(imemWe[d]), 32'd0);
      checkOutput("rstBusy", 32'(busySig[d]), 32'd0);
      checkOutput("rstDone", 32'(doneSig[d]), 32'd0);
      checkOutput("rstErr", 32'(errSig[d]), 32'd0);
      checkOutput("rstAddr", 32'(imemAddr[d]), 32'(base));
      checkOutput("rstWdata", 32'(imemWdata[d]), 32'd0);
      checkOutput("rstCpuHold", 32'(cpuHold[d]), 32'd1);
   endtask

   initial begin
      int n;
      for (int d = 0; d < 3; d++) begin
         resetSig[d] = 1'b1;
         startSig[d] = 1'b0;
         rxValid[d]  = 1'b0;
         rxData[d]   = 8'h00;
         obsCnt[d]   = 0;
         busyCnt[d]  = 0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) resetSig[d] = 1'b0;
      checkResetValues(0, 8'h00);
      checkResetValues(1, 8'hFE);

      $display("[TB] nominal load");
      loadWords[0] = 16'h1A23;
      loadWords[1] = 16'h2B45;
      runLoad(0, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] bad checksum then recovery");
      runLoad(0, 2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      runLoad(0, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] backpressure gaps");
      runLoad(0, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      $display("[TB] start during LO");
      runLoad(0, 2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

      $display("[TB] random loads");
      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) loadWords[i] = 16'($urandom);
         runLoad(0, n, 8'h00, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end

      $display("[TB] 256-word wrapping load");
      for (int i = 0; i < 256; i++) loadWords[i] = 16'($urandom);
      runLoad(1, 256, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset mid-load");
      obsCnt[1] = 0;
      pulseStart(1);
      applyStimulus(1, 8'h03, 1'b0, 1'b0);
      applyStimulus(1, 8'h12, 1'b0, 1'b0);
      applyStimulus(1, 8'h34, 1'b0, 1'b0);
      rxValid[1] = 1'b0;
      @(negedge clk);
      resetSig[1] = 1'b1;
      @(negedge clk);
      resetSig[1] = 1'b0;
      checkResetValues(1, 8'hFE);
      repeat (4) @(negedge clk);
      checkOutput("writesBeforeReset", obsCnt[1], 1);
      loadWords[0] = 16'hBEEF;
      loadWords[1] = 16'h0102;
      runLoad(1, 2, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] checksum disabled");
      loadWords[0] = 16'hF000;
      runLoad(2, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rxData[2]  = 8'hAA;
      rxValid[2] = 1'b1;
      @(negedge clk);
      checkOutput("noCsumReady", 32'(rxReady[2]), 32'd0);
      @(negedge clk);
      rxValid[2] = 1'b0;
      checkOutput("noCsumDone", 32'(doneSig[2]), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
